// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt front end: cause codes, FSM states and
// the default handler vectors that the control unit's trap path relies on.
package interrupt_controller_pkg;

    localparam int         ADDR_W_DEFAULT     = 9;
    localparam logic [8:0] NMI_VECTOR_DEFAULT = 9'h0A0;
    localparam logic [8:0] INT_VECTOR_DEFAULT = 9'h0C0;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_INT  = 2'b01;
    localparam logic [1:0] CAUSE_NMI  = 2'b10;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        REQUEST     = 2'b01,
        SERVICE_NMI = 2'b10,
        SERVICE_INT = 2'b11
    } ctrlState;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a rising-edge pulse derived from the synchronised
// level; the history flop's reset value is a parameter.
module sync_edge_detect #(
    parameter logic HIST_RESET = 1'b0
) (
    input  logic Clk,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut,
    output logic risePulse
);

    logic [1:0] syncStage;
    logic [1:0] fillStage;
    logic       prevSync;

    // The history flop holds its reset value until the synchroniser has filled,
    // so an input already high across reset release never looks like an edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            syncStage <= 2'b00;
            fillStage <= 2'b00;
            prevSync  <= HIST_RESET;
        end else begin
            syncStage <= {syncStage[0], asyncIn};
            fillStage <= {fillStage[0], 1'b1};
            if (fillStage[1]) begin
                prevSync <= syncStage[1];
            end
        end
    end

    assign syncOut   = syncStage[1];
    assign risePulse = syncStage[1] & ~prevSync;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front end: synchronises NMI and maskable inputs, holds IE and
// presents one trap request at a time under a request/ack/return handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] NMI_VECTOR = ADDR_W'(NMI_VECTOR_DEFAULT),
    parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(INT_VECTOR_DEFAULT)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              hardwareInterrupt,
    input  logic              maskableInterrupt,
    input  logic              intEnableSet,
    input  logic              intEnableClr,
    input  logic              trapAck,
    input  logic              trapReturn,
    output logic              trapRequest,
    output logic [ADDR_W-1:0] trapVector,
    output logic [1:0]        trapCause,
    output logic              intEnabled,
    output logic              nmiPending
);

    ctrlState          state, stateNext;
    logic              ieNext, savedIe, savedIeNext;
    logic              nmiPendingNext;
    logic [1:0]        causeNext;
    logic [ADDR_W-1:0] vectorNext;
    logic              inService;
    logic              syncNmi, nmiRise, syncInt;

    sync_edge_detect #(.HIST_RESET(1'b1)) nmiSync (
        .Clk       (Clk),
        .reset     (reset),
        .asyncIn   (hardwareInterrupt),
        .syncOut   (syncNmi),
        .risePulse (nmiRise)
    );

    sync_edge_detect #(.HIST_RESET(1'b0)) intSync (
        .Clk       (Clk),
        .reset     (reset),
        .asyncIn   (maskableInterrupt),
        .syncOut   (syncInt),
        .risePulse ()
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            intEnabled <= 1'b0;
            savedIe    <= 1'b0;
            nmiPending <= 1'b0;
            trapCause  <= CAUSE_NONE;
            trapVector <= '0;
        end else begin
            state      <= stateNext;
            intEnabled <= ieNext;
            savedIe    <= savedIeNext;
            nmiPending <= nmiPendingNext;
            trapCause  <= causeNext;
            trapVector <= vectorNext;
        end
    end

    always_comb begin
        stateNext      = state;
        ieNext         = intEnabled;
        savedIeNext    = savedIe;
        causeNext      = trapCause;
        vectorNext     = trapVector;
        nmiPendingNext = nmiPending | nmiRise;
        inService      = (state == SERVICE_NMI) || (state == SERVICE_INT);

        if (!inService) begin
            if (intEnableClr) begin
                ieNext = 1'b0;
            end else if (intEnableSet) begin
                ieNext = 1'b1;
            end
        end

        // An NMI edge seen this cycle becomes pending next edge; holding the
        // maskable request off for that cycle lets the NMI win a tie.
        case (state)
            IDLE: begin
                if (nmiPending) begin
                    stateNext  = REQUEST;
                    causeNext  = CAUSE_NMI;
                    vectorNext = NMI_VECTOR;
                end else if (syncInt && intEnabled && !nmiRise) begin
                    stateNext  = REQUEST;
                    causeNext  = CAUSE_INT;
                    vectorNext = INT_VECTOR;
                end
            end
            REQUEST: begin
                if (trapAck) begin
                    savedIeNext = intEnabled;
                    ieNext      = 1'b0;
                    if (trapCause == CAUSE_NMI) begin
                        nmiPendingNext = nmiRise;
                        stateNext      = SERVICE_NMI;
                    end else begin
                        stateNext = SERVICE_INT;
                    end
                end
            end
            SERVICE_NMI, SERVICE_INT: begin
                if (trapReturn) begin
                    ieNext     = savedIe;
                    causeNext  = CAUSE_NONE;
                    vectorNext = '0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign trapRequest = (state == REQUEST);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller: expectations are queued
// as stimulus is applied and drained against the outputs after each step.
module tb_interrupt_controller;

    logic       Clk;
    logic       reset;
    logic       hardwareInterrupt;
    logic       maskableInterrupt;
    logic       intEnableSet;
    logic       intEnableClr;
    logic       trapAck;
    logic       trapReturn;
    logic       trapRequest;
    logic [8:0] trapVector;
    logic [1:0] trapCause;
    logic       intEnabled;
    logic       nmiPending;

    typedef enum {F_REQ, F_VEC, F_CAUSE, F_IE, F_NMI} fieldSel;
    typedef struct {
        string      tag;
        fieldSel    field;
        logic [8:0] value;
    } sbEntry;

    sbEntry sb[$];
    int     assertCount = 0;
    int     failCount   = 0;

    interrupt_controller dut (
        .Clk               (Clk),
        .reset             (reset),
        .hardwareInterrupt (hardwareInterrupt),
        .maskableInterrupt (maskableInterrupt),
        .intEnableSet      (intEnableSet),
        .intEnableClr      (intEnableClr),
        .trapAck           (trapAck),
        .trapReturn        (trapReturn),
        .trapRequest       (trapRequest),
        .trapVector        (trapVector),
        .trapCause         (trapCause),
        .intEnabled        (intEnabled),
        .nmiPending        (nmiPending)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input fieldSel field, input logic [8:0] value);
        sbEntry e;
        e.tag   = tag;
        e.field = field;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic expectAll(input string tag, input logic req, input logic [8:0] vec,
                             input logic [1:0] cause, input logic ie, input logic nmi);
        expectOut({tag, ".req"},   F_REQ,   {8'd0, req});
        expectOut({tag, ".vec"},   F_VEC,   vec);
        expectOut({tag, ".cause"}, F_CAUSE, {7'd0, cause});
        expectOut({tag, ".ie"},    F_IE,    {8'd0, ie});
        expectOut({tag, ".nmi"},   F_NMI,   {8'd0, nmi});
    endtask

    // One-cycle pulses on the control-unit strobes, sampled by a single edge.
    task automatic applyStimulus(input logic set, input logic clr, input logic ack, input logic ret);
        intEnableSet = set;
        intEnableClr = clr;
        trapAck      = ack;
        trapReturn   = ret;
        tick();
        intEnableSet = 1'b0;
        intEnableClr = 1'b0;
        trapAck      = 1'b0;
        trapReturn   = 1'b0;
    endtask

    task automatic checkOutput();
        sbEntry     e;
        logic [8:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.field)
                F_REQ:   obs = {8'd0, trapRequest};
                F_VEC:   obs = trapVector;
                F_CAUSE: obs = {7'd0, trapCause};
                F_IE:    obs = {8'd0, intEnabled};
                default: obs = {8'd0, nmiPending};
            endcase
            assertCount++;
            assert (obs === e.value) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        hardwareInterrupt = 1'b1;
        maskableInterrupt = 1'b0;
        intEnableSet      = 1'b0;
        intEnableClr      = 1'b0;
        trapAck           = 1'b0;
        trapReturn        = 1'b0;

        $display("[TB] reset with NMI held high");
        tick(3);
        expectAll("rst", 1'b0, 9'h000, 2'b00, 1'b0, 1'b0);
        checkOutput();
        reset = 1'b0;
        tick(10);
        expectOut("nmiHeld.req", F_REQ, 9'd0);
        expectOut("nmiHeld.nmi", F_NMI, 9'd0);
        checkOutput();
        hardwareInterrupt = 1'b0;
        tick(4);

        $display("[TB] maskable request with IE=1");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectOut("ieSet", F_IE, 9'd1);
        checkOutput();
        maskableInterrupt = 1'b1;
        tick(2);
        expectOut("intE1.req", F_REQ, 9'd0);
        checkOutput();
        tick();
        expectAll("intE2", 1'b1, 9'h0C0, 2'b01, 1'b1, 1'b0);
        checkOutput();
        maskableInterrupt = 1'b0;
        tick();
        expectOut("intHold.req", F_REQ, 9'd1);
        expectOut("intHold.vec", F_VEC, 9'h0C0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectAll("intAck", 1'b0, 9'h0C0, 2'b01, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectOut("ieSetInService", F_IE, 9'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAll("intRet", 1'b0, 9'h000, 2'b00, 1'b1, 1'b0);
        checkOutput();
        tick(2);
        expectOut("intIdle.req", F_REQ, 9'd0);
        checkOutput();

        $display("[TB] IE priority and masked level");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        expectOut("clrBeatsSet", F_IE, 9'd0);
        checkOutput();
        maskableInterrupt = 1'b1;
        tick(20);
        expectOut("masked.req", F_REQ, 9'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectOut("unmask0.req", F_REQ, 9'd0);
        expectOut("unmask0.ie",  F_IE,  9'd1);
        checkOutput();
        tick();
        expectOut("unmask1.req",   F_REQ,   9'd1);
        expectOut("unmask1.cause", F_CAUSE, 9'd1);
        checkOutput();
        maskableInterrupt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expectAll("unmaskDone", 1'b0, 9'h000, 2'b00, 1'b1, 1'b0);
        checkOutput();

        $display("[TB] NMI and maskable in the same cycle");
        hardwareInterrupt = 1'b1;
        maskableInterrupt = 1'b1;
        tick(3);
        expectOut("tieE2.nmi", F_NMI, 9'd1);
        expectOut("tieE2.req", F_REQ, 9'd0);
        checkOutput();
        tick();
        expectAll("tieE3", 1'b1, 9'h0A0, 2'b10, 1'b1, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectAll("tieAck", 1'b0, 9'h0A0, 2'b10, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAll("tieRet", 1'b0, 9'h000, 2'b00, 1'b1, 1'b0);
        checkOutput();
        tick();
        expectAll("tieInt", 1'b1, 9'h0C0, 2'b01, 1'b1, 1'b0);
        checkOutput();
        maskableInterrupt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        hardwareInterrupt = 1'b0;
        tick(3);
        expectOut("tieDone.req", F_REQ, 9'd0);
        expectOut("tieDone.nmi", F_NMI, 9'd0);
        checkOutput();

        $display("[TB] NMI during maskable service");
        maskableInterrupt = 1'b1;
        tick(3);
        expectOut("svcReq.req",   F_REQ,   9'd1);
        expectOut("svcReq.cause", F_CAUSE, 9'd1);
        checkOutput();
        maskableInterrupt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        hardwareInterrupt = 1'b1;
        tick(3);
        expectOut("svcNmi.nmi", F_NMI, 9'd1);
        expectOut("svcNmi.req", F_REQ, 9'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAll("svcRet", 1'b0, 9'h000, 2'b00, 1'b1, 1'b1);
        checkOutput();
        tick();
        expectAll("svcNmiReq", 1'b1, 9'h0A0, 2'b10, 1'b1, 1'b1);
        checkOutput();

        $display("[TB] new NMI edge coinciding with NMI ack");
        hardwareInterrupt = 1'b0;
        tick(3);
        expectOut("nmiWait.req", F_REQ, 9'd1);
        checkOutput();
        hardwareInterrupt = 1'b1;
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectAll("ackEdge", 1'b0, 9'h0A0, 2'b10, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectOut("ackEdgeRet.req", F_REQ, 9'd0);
        expectOut("ackEdgeRet.ie",  F_IE,  9'd1);
        checkOutput();
        tick();
        expectAll("ackEdgeReq", 1'b1, 9'h0A0, 2'b10, 1'b1, 1'b1);
        checkOutput();

        $display("[TB] asynchronous reset while requesting");
        reset = 1'b1;
        #1;
        expectAll("asyncRst", 1'b0, 9'h000, 2'b00, 1'b0, 1'b0);
        checkOutput();
        tick(2);
        hardwareInterrupt = 1'b0;
        reset = 1'b0;
        tick(3);

        $display("[TB] stray ack/return in IDLE");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectAll("stray", 1'b0, 9'h000, 2'b00, 1'b0, 1'b0);
        checkOutput();
        tick();
        expectOut("strayLater.req", F_REQ, 9'd0);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
